// File: rtl/yonga_can_tx_scheduler.sv
// yonga_can_tx_scheduler
// Four-mailbox CAN transmit scheduler. Picks the pending mailbox with the
// lowest {id,~ide} arbitration key, asks the controller to send it, and
// resolves the controller's outcome into done/retry (and optionally fail).
// Optional feature macro: YONGA_CAN_SCHED_RETRY_LIMIT_EN. When it is defined,
// a mailbox is aborted after MAX_RETRY failed attempts.
module yonga_can_tx_scheduler #(
    parameter int NUM_MB    = 4,
    parameter int MAX_RETRY = 8
) (
    input  logic              i_sched_clk,
    input  logic              i_sched_rst_n,
    input  logic [NUM_MB-1:0] i_mb_set,
    input  logic [28:0]       i_mb_id,
    input  logic              i_mb_ide,
    input  logic [NUM_MB-1:0] i_mb_cancel,
    input  logic [2:0]        i_ctrl_sts_code,
    input  logic              i_ctrl_done,
    output logic              o_ctrl_send,
    output logic [1:0]        o_sel_idx,
    output logic [28:0]       o_sel_id,
    output logic              o_sel_ide,
    output logic [NUM_MB-1:0] o_mb_pending,
    output logic [NUM_MB-1:0] o_mb_done,
    output logic [NUM_MB-1:0] o_mb_fail,
    output logic              o_busy
);

    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_max_retry
        $error("MAX_RETRY must fit the 4-bit retry counter");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SEND,
        ST_RESOLVE
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_MB-1:0] pending_q;
    logic [28:0]       id_q      [NUM_MB];
    logic              ide_q     [NUM_MB];
    logic [3:0]        retry_cnt [NUM_MB];
    logic [2:0]        sts_q;
    logic              cancel_def_q;
    logic [1:0]        sel_idx_q;
    logic [28:0]       sel_id_q;
    logic              sel_ide_q;

    logic              win_found;
    logic [1:0]        win_idx;
    logic [29:0]       win_key;
    logic [NUM_MB-1:0] lock_oh;
    logic [NUM_MB-1:0] sel_oh;
    logic [3:0]        retry_sel;
    logic [3:0]        retry_inc;
    logic              resolving;
    logic              success;
    logic              cancel_now;
    logic              abort;

    // Arbitration: lowest {id,~ide} wins; strict compare keeps the lowest index on ties
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_key   = '1;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (pending_q[i] && (!win_found || {id_q[i], ~ide_q[i]} < win_key)) begin
                win_found = 1'b1;
                win_idx   = 2'(i);
                win_key   = {id_q[i], ~ide_q[i]};
            end
        end
    end

    // Locked mailbox (being selected or in flight) ignores set and defers cancel
    always_comb begin
        sel_oh            = '0;
        sel_oh[sel_idx_q] = 1'b1;
        lock_oh           = '0;
        case (state_q)
            ST_SELECT:           if (win_found) lock_oh[win_idx] = 1'b1;
            ST_SEND, ST_RESOLVE: lock_oh = sel_oh;
            default:             lock_oh = '0;
        endcase
    end

    // Outcome of the RESOLVE cycle for the selected mailbox
    always_comb begin
        retry_sel  = retry_cnt[sel_idx_q];
        retry_inc  = (retry_sel == 4'hF) ? 4'hF : retry_sel + 4'd1;
        resolving  = (state_q == ST_RESOLVE);
        success    = resolving && (sts_q == 3'd3);
        cancel_now = cancel_def_q || i_mb_cancel[sel_idx_q];
`ifdef YONGA_CAN_SCHED_RETRY_LIMIT_EN
        abort      = resolving && !success && !cancel_now &&
                     (({1'b0, retry_sel} + 5'd1) == 5'(MAX_RETRY));
`else
        abort      = 1'b0;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pending_q != '0) state_d = ST_SELECT;
            ST_SELECT:  state_d = win_found ? ST_SEND : ST_IDLE;
            ST_SEND:    if (i_ctrl_sts_code == 3'd2 || i_ctrl_done) state_d = ST_RESOLVE;
            ST_RESOLVE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State, mailbox storage, status latch and selection registers
    always_ff @(posedge i_sched_clk) begin
        if (!i_sched_rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            sts_q        <= '0;
            cancel_def_q <= 1'b0;
            sel_idx_q    <= '0;
            sel_id_q     <= '0;
            sel_ide_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_MB; i++) begin
                id_q[i]      <= '0;
                ide_q[i]     <= 1'b0;
                retry_cnt[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int unsigned i = 0; i < NUM_MB; i++) begin
                if (i_mb_cancel[i] && !lock_oh[i]) begin
                    pending_q[i] <= 1'b0;
                end else if (i_mb_set[i] && !lock_oh[i]) begin
                    pending_q[i] <= 1'b1;
                    id_q[i]      <= i_mb_id;
                    ide_q[i]     <= i_mb_ide;
                    retry_cnt[i] <= '0;
                end
            end
            case (state_q)
                ST_SELECT: begin
                    sel_idx_q    <= win_idx;
                    sel_id_q     <= id_q[win_idx];
                    sel_ide_q    <= ide_q[win_idx];
                    sts_q        <= '0;
                    cancel_def_q <= win_found && i_mb_cancel[win_idx];
                end
                ST_SEND: begin
                    if (i_mb_cancel[sel_idx_q]) cancel_def_q <= 1'b1;
                    // No-ack is sticky; ack or arbitration loss overrides it
                    if (i_ctrl_sts_code == 3'd2 || i_ctrl_sts_code == 3'd3)
                        sts_q <= i_ctrl_sts_code;
                    else if (i_ctrl_sts_code == 3'd1 && sts_q == 3'd0)
                        sts_q <= 3'd1;
                end
                ST_RESOLVE: begin
                    if (success) begin
                        pending_q[sel_idx_q] <= 1'b0;
                        retry_cnt[sel_idx_q] <= '0;
                    end else if (cancel_now) begin
                        pending_q[sel_idx_q] <= 1'b0;
                    end else begin
                        retry_cnt[sel_idx_q] <= retry_inc;
                        if (abort) pending_q[sel_idx_q] <= 1'b0;
                    end
                    sts_q        <= '0;
                    cancel_def_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ctrl_send  = (state_q == ST_SEND);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_sel_idx    = sel_idx_q;
    assign o_sel_id     = sel_id_q;
    assign o_sel_ide    = sel_ide_q;
    assign o_mb_pending = pending_q;
    assign o_mb_done    = success ? sel_oh : '0;
`ifdef YONGA_CAN_SCHED_RETRY_LIMIT_EN
    assign o_mb_fail    = abort ? sel_oh : '0;
`else
    assign o_mb_fail    = '0;
`endif

endmodule

// File: tb/tb_yonga_can_tx_scheduler.sv
// Directed testbench for yonga_can_tx_scheduler.
// Covers the default build and, when YONGA_CAN_SCHED_RETRY_LIMIT_EN is
// defined, the retry-limit abort path.
module tb_yonga_can_tx_scheduler;

    logic        i_sched_clk = 1'b0;
    logic        i_sched_rst_n;
    logic [3:0]  i_mb_set;
    logic [28:0] i_mb_id;
    logic        i_mb_ide;
    logic [3:0]  i_mb_cancel;
    logic [2:0]  i_ctrl_sts_code;
    logic        i_ctrl_done;
    logic        o_ctrl_send;
    logic [1:0]  o_sel_idx;
    logic [28:0] o_sel_id;
    logic        o_sel_ide;
    logic [3:0]  o_mb_pending;
    logic [3:0]  o_mb_done;
    logic [3:0]  o_mb_fail;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    yonga_can_tx_scheduler #(.NUM_MB(4), .MAX_RETRY(8)) dut (
        .i_sched_clk     (i_sched_clk),
        .i_sched_rst_n   (i_sched_rst_n),
        .i_mb_set        (i_mb_set),
        .i_mb_id         (i_mb_id),
        .i_mb_ide        (i_mb_ide),
        .i_mb_cancel     (i_mb_cancel),
        .i_ctrl_sts_code (i_ctrl_sts_code),
        .i_ctrl_done     (i_ctrl_done),
        .o_ctrl_send     (o_ctrl_send),
        .o_sel_idx       (o_sel_idx),
        .o_sel_id        (o_sel_id),
        .o_sel_ide       (o_sel_ide),
        .o_mb_pending    (o_mb_pending),
        .o_mb_done       (o_mb_done),
        .o_mb_fail       (o_mb_fail),
        .o_busy          (o_busy)
    );

    always #5 i_sched_clk = ~i_sched_clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later
    task automatic tick();
        @(posedge i_sched_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_mb_set        = '0;
        i_mb_cancel     = '0;
        i_ctrl_sts_code = '0;
        i_ctrl_done     = 1'b0;
    endtask

    task automatic load(input logic [3:0] mask, input logic [28:0] id, input logic ide);
        i_mb_set = mask;
        i_mb_id  = id;
        i_mb_ide = ide;
        tick();
        i_mb_set = '0;
    endtask

    // Bounded wait for o_ctrl_send; expiry is a failed comparison
    task automatic wait_send(input string name);
        for (int i = 0; i < 10; i++) begin
            if (o_ctrl_send) break;
            tick();
        end
        checks++;
        if (o_ctrl_send !== 1'b1) begin
            errors++;
            $display("FAIL %s: send timeout, got %b want 1", name, o_ctrl_send);
        end
    endtask

    // Finish the current transmission with the given status plus done
    task automatic finish_tx(input logic [2:0] sts);
        i_ctrl_sts_code = sts;
        i_ctrl_done     = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        i_mb_id = '0; i_mb_ide = 1'b0;
        i_sched_rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({o_ctrl_send, o_busy, o_mb_pending, o_mb_done, o_mb_fail, o_sel_idx, o_sel_ide} !== '0 || o_sel_id !== '0) begin
            errors++;
            $display("FAIL reset: send=%b busy=%b pend=%b done=%b fail=%b idx=%0d id=%h want all 0",
                     o_ctrl_send, o_busy, o_mb_pending, o_mb_done, o_mb_fail, o_sel_idx, o_sel_id);
        end
        i_sched_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        load(4'b0100, 29'(11'h100) << 18, 1'b0);
        checks++;
        if (o_mb_pending !== 4'b0100 || o_ctrl_send !== 1'b0) begin
            errors++; $display("FAIL single_pend: pend=%b send=%b want 0100/0", o_mb_pending, o_ctrl_send);
        end
        tick();
        checks++;
        if (o_ctrl_send !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL single_select: send=%b busy=%b want 0/1", o_ctrl_send, o_busy);
        end
        tick();
        checks++;
        if (o_ctrl_send !== 1'b1 || o_sel_idx !== 2'd2 || o_sel_id !== (29'(11'h100) << 18) || o_sel_ide !== 1'b0) begin
            errors++; $display("FAIL single_send: send=%b idx=%0d id=%h want 1/2/%h", o_ctrl_send, o_sel_idx, o_sel_id, 29'(11'h100) << 18);
        end
        finish_tx(3'd3);
        checks++;
        if (o_ctrl_send !== 1'b0 || o_mb_done !== 4'b0100 || o_mb_fail !== 4'b0000) begin
            errors++; $display("FAIL single_done: send=%b done=%b fail=%b want 0/0100/0000", o_ctrl_send, o_mb_done, o_mb_fail);
        end
        tick();
        checks++;
        if (o_mb_pending !== 4'b0000 || o_mb_done !== 4'b0000 || o_busy !== 1'b0) begin
            errors++; $display("FAIL single_clear: pend=%b done=%b busy=%b want 0/0/0", o_mb_pending, o_mb_done, o_busy);
        end
    endtask

    task automatic test_priority();
        // Both loaded before the SELECT cycle samples the pending set
        load(4'b0001, 29'(11'h200) << 18, 1'b0);
        load(4'b1000, 29'(11'h050) << 18, 1'b0);
        wait_send("prio_first_wait");
        checks++;
        if (o_sel_idx !== 2'd3 || o_sel_id !== (29'(11'h050) << 18)) begin
            errors++; $display("FAIL prio_first: idx=%0d id=%h want 3/%h", o_sel_idx, o_sel_id, 29'(11'h050) << 18);
        end
        finish_tx(3'd3);
        tick();
        wait_send("prio_second_wait");
        checks++;
        if (o_sel_idx !== 2'd0 || o_mb_pending !== 4'b0001) begin
            errors++; $display("FAIL prio_second: idx=%0d pend=%b want 0/0001", o_sel_idx, o_mb_pending);
        end
        finish_tx(3'd3);
        tick();
        // Identical keys: lowest index wins
        load(4'b0110, 29'h0ABCDEF, 1'b1);
        wait_send("prio_tie_wait");
        checks++;
        if (o_sel_idx !== 2'd1 || o_sel_ide !== 1'b1) begin
            errors++; $display("FAIL prio_tie: idx=%0d ide=%b want 1/1", o_sel_idx, o_sel_ide);
        end
        finish_tx(3'd3);
        tick();
        wait_send("prio_tie2_wait");
        finish_tx(3'd3);
        tick();
    endtask

    task automatic test_arb_lost();
        load(4'b0010, 29'(11'h123) << 18, 1'b0);
        wait_send("arb_wait");
        i_ctrl_sts_code = 3'd2;
        tick();
        idle_inputs();
        checks++;
        if (o_ctrl_send !== 1'b0 || o_mb_done !== 4'b0000) begin
            errors++; $display("FAIL arb_drop: send=%b done=%b want 0/0000", o_ctrl_send, o_mb_done);
        end
        tick();
        checks++;
        if (dut.retry_cnt[1] !== 4'd1 || o_mb_pending !== 4'b0010) begin
            errors++; $display("FAIL arb_retry: retry=%0d pend=%b want 1/0010", dut.retry_cnt[1], o_mb_pending);
        end
        tick(); tick();
        checks++;
        if (o_ctrl_send !== 1'b1 || o_sel_idx !== 2'd1) begin
            errors++; $display("FAIL arb_reselect: send=%b idx=%0d want 1/1", o_ctrl_send, o_sel_idx);
        end
        // No-ack followed by a quiet done cycle still counts as a failure
        i_ctrl_sts_code = 3'd1;
        tick();
        finish_tx(3'd0);
        tick();
        checks++;
        if (dut.retry_cnt[1] !== 4'd2 || o_mb_pending !== 4'b0010) begin
            errors++; $display("FAIL noack_sticky: retry=%0d pend=%b want 2/0010", dut.retry_cnt[1], o_mb_pending);
        end
        wait_send("arb_final_wait");
        finish_tx(3'd3);
        tick();
        checks++;
        if (dut.retry_cnt[1] !== 4'd0 || o_mb_pending !== 4'b0000) begin
            errors++; $display("FAIL arb_ack_clear: retry=%0d pend=%b want 0/0000", dut.retry_cnt[1], o_mb_pending);
        end
    endtask

    task automatic test_retry_limit();
        load(4'b0010, 29'h0000777, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            wait_send("retry_wait");
            i_ctrl_sts_code = 3'd1;
            tick();
            finish_tx(3'd0);
            checks++;
`ifdef YONGA_CAN_SCHED_RETRY_LIMIT_EN
            if (o_mb_fail !== ((n == 8) ? 4'b0010 : 4'b0000)) begin
                errors++; $display("FAIL retry_fail_pulse: attempt %0d fail=%b want %b", n, o_mb_fail, (n == 8) ? 4'b0010 : 4'b0000);
            end
`else
            if (o_mb_fail !== 4'b0000) begin
                errors++; $display("FAIL retry_fail_pulse: attempt %0d fail=%b want 0000", n, o_mb_fail);
            end
`endif
            tick();
        end
        checks++;
`ifdef YONGA_CAN_SCHED_RETRY_LIMIT_EN
        if (o_mb_pending !== 4'b0000) begin
            errors++; $display("FAIL retry_abort: pend=%b want 0000", o_mb_pending);
        end
`else
        if (o_mb_pending !== 4'b0010) begin
            errors++; $display("FAIL retry_unlimited: pend=%b want 0010", o_mb_pending);
        end
        wait_send("retry_ninth_wait");
        checks++;
        if (o_sel_idx !== 2'd1 || dut.retry_cnt[1] !== 4'd8) begin
            errors++; $display("FAIL retry_ninth: idx=%0d retry=%0d want 1/8", o_sel_idx, dut.retry_cnt[1]);
        end
        i_mb_cancel = 4'b0010;
        finish_tx(3'd1);
        tick();
`endif
    endtask

    task automatic test_cancel();
        // Deferred cancel with a failing outcome: silent removal
        load(4'b0010, 29'(11'h010) << 18, 1'b0);
        wait_send("cancel_wait");
        i_mb_cancel = 4'b0010;
        tick();
        i_mb_cancel = '0;
        checks++;
        if (o_mb_pending !== 4'b0010 || o_ctrl_send !== 1'b1) begin
            errors++; $display("FAIL cancel_deferred: pend=%b send=%b want 0010/1", o_mb_pending, o_ctrl_send);
        end
        // Set on the in-flight mailbox is ignored
        load(4'b0010, 29'h1FFFFFFF, 1'b1);
        checks++;
        if (o_sel_id !== (29'(11'h010) << 18) || o_sel_ide !== 1'b0) begin
            errors++; $display("FAIL set_locked: id=%h ide=%b want %h/0", o_sel_id, o_sel_ide, 29'(11'h010) << 18);
        end
        finish_tx(3'd1);
        checks++;
        if (o_mb_done !== 4'b0000 || o_mb_fail !== 4'b0000) begin
            errors++; $display("FAIL cancel_nopulse: done=%b fail=%b want 0000/0000", o_mb_done, o_mb_fail);
        end
        tick();
        checks++;
        if (o_mb_pending !== 4'b0000) begin
            errors++; $display("FAIL cancel_clear: pend=%b want 0000", o_mb_pending);
        end
        // Deferred cancel with an acked outcome: success wins
        load(4'b0010, 29'(11'h010) << 18, 1'b0);
        wait_send("cancel_ack_wait");
        i_mb_cancel = 4'b0010;
        tick();
        i_mb_cancel = '0;
        finish_tx(3'd3);
        checks++;
        if (o_mb_done !== 4'b0010) begin
            errors++; $display("FAIL cancel_ack_done: done=%b want 0010", o_mb_done);
        end
        tick();
        // Cancel of a non-selected mailbox takes effect on the next edge
        load(4'b0010, 29'(11'h001) << 18, 1'b0);
        load(4'b1000, 29'(11'h7FF) << 18, 1'b0);
        wait_send("cancel_other_wait");
        i_mb_cancel = 4'b1000;
        tick();
        i_mb_cancel = '0;
        checks++;
        if (o_mb_pending !== 4'b0010 || o_sel_idx !== 2'd1) begin
            errors++; $display("FAIL cancel_other: pend=%b idx=%0d want 0010/1", o_mb_pending, o_sel_idx);
        end
        finish_tx(3'd3);
        tick();
        // Simultaneous set and cancel on an idle mailbox: cancel wins, FSM stays idle
        i_mb_cancel = 4'b0001;
        load(4'b0001, 29'h55, 1'b0);
        i_mb_cancel = '0;
        tick();
        checks++;
        if (o_mb_pending !== 4'b0000 || o_busy !== 1'b0 || o_ctrl_send !== 1'b0) begin
            errors++; $display("FAIL set_cancel_same: pend=%b busy=%b send=%b want 0000/0/0", o_mb_pending, o_busy, o_ctrl_send);
        end
    endtask

    task automatic test_reset_mid_send();
        load(4'b0100, 29'(11'h300) << 18, 1'b0);
        wait_send("rst_wait");
        i_sched_rst_n = 1'b0;
        i_ctrl_sts_code = 3'd3;
        i_ctrl_done = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({o_ctrl_send, o_busy, o_mb_pending, o_mb_done, o_mb_fail, o_sel_idx} !== '0 || o_sel_id !== '0) begin
            errors++; $display("FAIL rst_mid_send: send=%b busy=%b pend=%b done=%b fail=%b idx=%0d want all 0",
                               o_ctrl_send, o_busy, o_mb_pending, o_mb_done, o_mb_fail, o_sel_idx);
        end
        i_sched_rst_n = 1'b1;
        tick();
        load(4'b0001, 29'h0012345, 1'b1);
        tick(); tick();
        checks++;
        if (o_ctrl_send !== 1'b1 || o_sel_idx !== 2'd0 || o_sel_id !== 29'h0012345 || o_sel_ide !== 1'b1) begin
            errors++; $display("FAIL rst_rearb: send=%b idx=%0d id=%h ide=%b want 1/0/0012345/1", o_ctrl_send, o_sel_idx, o_sel_id, o_sel_ide);
        end
        finish_tx(3'd3);
        checks++;
        if (o_mb_done !== 4'b0001) begin
            errors++; $display("FAIL rst_rearb_done: done=%b want 0001", o_mb_done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_arb_lost();
        test_retry_limit();
        test_cancel();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
